// File: rtl/wb_arbiter.sv
// wb_arbiter
// Merges single-cycle ALU results and buffered, variable-latency load results
// onto the register bank's single write port. Exactly one registered write
// (RegW/Rd/wrData) is presented per cycle. The ALU normally wins the port; the
// load FIFO head is forced through after STARVE_MAX consecutive losses.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   alu_valid/alu_ready  ALU result handshake; alu_rd/alu_data carry the write
//   mem_valid/mem_ready  load result handshake into the FIFO; mem_rd/mem_data
//   RegW, Rd, wrData     registered bank write port
//   q_reg, q_pending     interlock query: is a write to q_reg still in flight
//   busy                 load FIFO non-empty
//   err                  sticky: a write to an index >= 16 was dropped
module wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              RegW,
    output logic [ADDR_W-1:0] Rd,
    output logic [DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0] q_reg,
    output logic              q_pending,
    output logic              busy,
    output logic              err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [ADDR_W-1:0] fifo_rd_q   [DEPTH];
    logic [ADDR_W-1:0] fifo_rd_d   [DEPTH];
    logic [DATA_W-1:0] fifo_data_q [DEPTH];
    logic [DATA_W-1:0] fifo_data_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic              regw_q, regw_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] wrdata_q, wrdata_d;
    logic              err_q, err_d;

    logic fifo_empty, starved;
    logic alu_xfer, mem_xfer, alu_keep, mem_keep, alu_oor, mem_oor;
    logic pop, push, fifo_hit;

    // Bank implements R0..R15; anything with a set bit at or above bit 4 is out of range.
    function automatic logic out_of_range(input logic [ADDR_W-1:0] rd);
        return 32'(rd) > 32'd15;
    endfunction

    assign fifo_empty = (count_q == '0);
    assign starved    = (starve_q == SC_W'(STARVE_MAX));
    assign busy       = !fifo_empty;
    // Ready depends only on registered count: no combinational ready-from-pop path.
    assign mem_ready  = (count_q < CNT_W'(DEPTH));
    assign alu_ready  = !(starved && busy);

    assign alu_xfer = alu_valid && alu_ready;
    assign mem_xfer = mem_valid && mem_ready;
    assign alu_oor  = out_of_range(alu_rd);
    assign mem_oor  = out_of_range(mem_rd);
    // R0 writes and out-of-range writes complete the handshake but are discarded.
    assign alu_keep = alu_xfer && (alu_rd != '0) && !alu_oor;
    assign mem_keep = mem_xfer && (mem_rd != '0) && !mem_oor;
    assign push     = mem_keep;

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        starve_d    = starve_q;
        regw_d      = 1'b0;
        rd_d        = rd_q;
        wrdata_d    = wrdata_q;
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        pop         = 1'b0;

        if (starved && busy) begin
            pop = 1'b1;
        end else if (alu_keep) begin
            regw_d   = 1'b1;
            rd_d     = alu_rd;
            wrdata_d = alu_data;
        end else if (busy) begin
            pop = 1'b1;
        end

        if (pop) begin
            regw_d   = 1'b1;
            rd_d     = fifo_rd_q[rd_ptr_q];
            wrdata_d = fifo_data_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // Non-empty and no pop means the ALU took the port this cycle.
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (!starved) begin
            starve_d = starve_q + SC_W'(1);
        end

        if (push) begin
            fifo_rd_d[wr_ptr_q]   = mem_rd;
            fifo_data_d[wr_ptr_q] = mem_data;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    assign err_d = err_q || (alu_xfer && alu_oor) || (mem_xfer && mem_oor);

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        fifo_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, PTR_W'(i) - rd_ptr_q} < count_q && fifo_rd_q[i] == q_reg) begin
                fifo_hit = 1'b1;
            end
        end
    end

    assign q_pending = (q_reg != '0) && ((regw_q && rd_q == q_reg) || fifo_hit);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            regw_q   <= 1'b0;
            rd_q     <= '0;
            wrdata_q <= '0;
            err_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            regw_q   <= regw_d;
            rd_q     <= rd_d;
            wrdata_q <= wrdata_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: entries are only read once count marks them live.
    always_ff @(posedge clk) begin
        fifo_rd_q   <= fifo_rd_d;
        fifo_data_q <= fifo_data_d;
    end

    assign RegW   = regw_q;
    assign Rd     = rd_q;
    assign wrData = wrdata_q;
    assign err    = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter
// Directed scenarios followed by a random phase; every cycle the DUT is
// compared against a queue-based behavioural model of the arbiter.
module tb_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;
    localparam int SMAX   = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              alu_valid, alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid, mem_ready;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              RegW;
    logic [ADDR_W-1:0] Rd;
    logic [DATA_W-1:0] wrData;
    logic [ADDR_W-1:0] q_reg;
    logic              q_pending, busy, err;

    wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .RegW(RegW), .Rd(Rd), .wrData(wrData),
        .q_reg(q_reg), .q_pending(q_pending), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              mq[$];
    logic              m_regw;
    logic [ADDR_W-1:0] m_rd;
    logic [DATA_W-1:0] m_wd;
    logic              m_err;
    int                m_starve;
    logic              m_mem_xfer;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_regw     = 1'b0;
        m_rd       = '0;
        m_wd       = '0;
        m_err      = 1'b0;
        m_starve   = 0;
        m_mem_xfer = 1'b0;
    endtask

    function automatic logic m_pending();
        if (q_reg == '0) return 1'b0;
        if (m_regw && m_rd == q_reg) return 1'b1;
        foreach (mq[i]) if (mq[i].rd == q_reg) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic valid_rd(input logic [ADDR_W-1:0] r);
        return (r != '0) && (r < 16);
    endfunction

    // Advance the model across the coming clock edge using the current inputs.
    task automatic model_step();
        logic busy_m, ar, mr, ax, mx;
        ent_t e;
        busy_m = (mq.size() != 0);
        ar     = !(m_starve == SMAX && busy_m);
        mr     = (mq.size() < DEPTH);
        ax     = alu_valid && ar;
        mx     = mem_valid && mr;
        if (reset) begin
            model_reset();
            return;
        end
        m_mem_xfer = mx;
        if (ax && alu_rd >= 16) m_err = 1'b1;
        if (mx && mem_rd >= 16) m_err = 1'b1;
        if (busy_m && (m_starve == SMAX || !(ax && valid_rd(alu_rd)))) begin
            e        = mq.pop_front();
            m_regw   = 1'b1;
            m_rd     = e.rd;
            m_wd     = e.d;
            m_starve = 0;
        end else if (ax && valid_rd(alu_rd)) begin
            m_regw   = 1'b1;
            m_rd     = alu_rd;
            m_wd     = alu_data;
            m_starve = busy_m ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
        end else begin
            m_regw   = 1'b0;
            m_starve = 0;
        end
        if (mx && valid_rd(mem_rd)) mq.push_back('{rd: mem_rd, d: mem_data});
    endtask

    // Called just after a falling edge with inputs set; returns at the next falling edge.
    task automatic cycle();
        #1;
        chk("regw",      RegW,      m_regw);
        chk("rd",        Rd,        m_rd);
        chk("wrdata",    wrData,    m_wd);
        chk("err",       err,       m_err);
        chk("busy",      busy,      mq.size() != 0);
        chk("mem_ready", mem_ready, mq.size() < DEPTH);
        chk("alu_ready", alu_ready, !(m_starve == SMAX && mq.size() != 0));
        chk("q_pending", q_pending, m_pending());
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    endtask

    function automatic logic [ADDR_W-1:0] rand_rd();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return '0;
        if (r == 1) return ADDR_W'($urandom_range(16, 31));
        return ADDR_W'($urandom_range(1, 7));
    endfunction

    initial begin
        int sent;
        int saw_full;
        reset = 1'b1;
        q_reg = '0;
        idle_inputs();
        repeat (2) @(negedge clk);
        model_reset();

        chk("rst_regw",      RegW,      1'b0);
        chk("rst_rd",        Rd,        '0);
        chk("rst_wrdata",    wrData,    '0);
        chk("rst_err",       err,       1'b0);
        chk("rst_busy",      busy,      1'b0);
        chk("rst_mem_ready", mem_ready, 1'b1);
        chk("rst_alu_ready", alu_ready, 1'b1);
        reset = 1'b0;
        cycle();

        // Single ALU write and its latency.
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
        cycle();
        chk("alu_lat_regw",   RegW,   1'b1);
        chk("alu_lat_rd",     Rd,     32'd3);
        chk("alu_lat_wrdata", wrData, 32'h11);
        idle_inputs();
        cycle();
        chk("alu_pulse_end", RegW, 1'b0);

        // Four loads with the ALU idle drain in order.
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1'b1; mem_rd = ADDR_W'(i + 1); mem_data = 32'hA1 + 32'(i);
            chk("load_mem_ready", mem_ready, 1'b1);
            cycle();
        end
        idle_inputs();
        repeat (4) cycle();
        chk("load_drained_busy", busy, 1'b0);

        // Six loads against a continuously valid ALU to R5.
        sent = 0;
        saw_full = 0;
        alu_valid = 1'b1; alu_rd = 5'd5;
        for (int c = 0; c < 60; c++) begin
            alu_data  = 32'h500 + 32'(c);
            mem_valid = (sent < 6);
            mem_rd    = ADDR_W'(8 + sent);
            mem_data  = 32'hB0 + 32'(sent);
            if (!mem_ready) saw_full = 1;
            cycle();
            if (m_mem_xfer) sent++;
            if (sent == 6 && mq.size() == 0) break;
        end
        chk("six_loads_sent", sent, 6);
        chk("six_saw_full", saw_full, 1);
        idle_inputs();
        repeat (3) cycle();

        // Filtered requests: R0 on both sides, then an out-of-range load.
        alu_valid = 1'b1; alu_rd = '0; alu_data = 32'hDEAD;
        mem_valid = 1'b1; mem_rd = '0; mem_data = 32'hBEEF;
        cycle();
        idle_inputs();
        chk("r0_no_write", RegW, 1'b0);
        chk("r0_no_store", busy, 1'b0);
        mem_valid = 1'b1; mem_rd = 5'd17; mem_data = 32'h17;
        cycle();
        idle_inputs();
        chk("oor_err_set", err, 1'b1);
        repeat (3) cycle();
        chk("oor_err_sticky", err, 1'b1);

        // R7 queued behind a full FIFO, watched through q_pending.
        q_reg = 5'd7;
        sent = 0;
        alu_valid = 1'b1; alu_rd = 5'd2;
        for (int c = 0; c < 40; c++) begin
            alu_data  = 32'h200 + 32'(c);
            mem_valid = (sent < 5);
            mem_rd    = (sent < 4) ? ADDR_W'(sent + 1) : 5'd7;
            mem_data  = 32'hC0 + 32'(sent);
            cycle();
            if (m_mem_xfer) sent++;
            if (sent == 5 && mq.size() == 0 && !m_regw) break;
        end
        chk("r7_sent", sent, 5);
        idle_inputs();
        cycle();
        chk("r7_pending_clear", q_pending, 1'b0);
        q_reg = '0;
        cycle();
        chk("qreg0_pending", q_pending, 1'b0);

        // Hold three entries, then reset.
        alu_valid = 1'b1; alu_rd = 5'd4;
        for (int i = 0; i < 3; i++) begin
            alu_data = 32'h40 + 32'(i);
            mem_valid = 1'b1; mem_rd = ADDR_W'(9 + i); mem_data = 32'hD0 + 32'(i);
            cycle();
        end
        chk("pre_reset_busy", busy, 1'b1);
        idle_inputs();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("post_reset_regw",      RegW,      1'b0);
        chk("post_reset_busy",      busy,      1'b0);
        chk("post_reset_mem_ready", mem_ready, 1'b1);
        chk("post_reset_err",       err,       1'b0);
        cycle();
        chk("post_reset_no_emerge", RegW, 1'b0);

        // Random phase.
        for (int c = 0; c < 600; c++) begin
            reset     = ($urandom_range(0, 99) == 0);
            alu_valid = ($urandom_range(0, 3) != 0);
            alu_rd    = rand_rd();
            alu_data  = $urandom;
            mem_valid = ($urandom_range(0, 2) != 0);
            mem_rd    = rand_rd();
            mem_data  = $urandom;
            q_reg     = ADDR_W'($urandom_range(0, 7));
            cycle();
        end
        reset = 1'b0;
        idle_inputs();
        repeat (8) cycle();
        chk("final_drained", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter sitting directly upstream of the register bank. It merges single-cycle ALU results and variable-latency load results into the bank's single write port. Load results are buffered in a small FIFO, and each cycle exactly one registered write (RegW/Rd/wrData) is presented to the bank. It also provides a pending-write query so issue logic can interlock on registers with writes still in flight.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register index width (bank implements R0–R15)
- DEPTH, 4, load FIFO entries (power of 2, ≥2)
- STARVE_MAX, 3, consecutive cycles the FIFO head may lose to the ALU before it is forced through
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU result available this cycle
- alu_ready  out  1  ALU result accepted when alu_valid && alu_ready
- alu_rd  in  ADDR_W  ALU destination
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load result available
- mem_ready  out  1  FIFO can accept (= count < DEPTH)
- mem_rd  in  ADDR_W  load destination
- mem_data  in  DATA_W  load data
- RegW  out  1  bank write enable (registered)
- Rd  out  ADDR_W  bank write index (registered)
- wrData  out  DATA_W  bank write data (registered)
- q_reg  in  ADDR_W  register being checked by issue logic
- q_pending  out  1  a write to q_reg is queued or is on the output
- busy  out  1  FIFO non-empty
- err  out  1  sticky: write to out-of-range index (rd[4]=1) dropped

## Operation
- Transfers:
  - A load transfer occurs when mem_valid && mem_ready.
  - An ALU transfer occurs when alu_valid && alu_ready.
- Filtering at input:
  - rd==0: a transfer still occurs but nothing is stored or emitted.
  - rd≥16: the write is dropped and err is set.
  - A filtered ALU request does not claim the output slot.
- Load FIFO:
  - Circular buffer with rd_ptr/wr_ptr of log2(DEPTH) bits, wrapping modulo DEPTH.
  - count is 0..DEPTH.
  - A push and a pop in the same cycle leave count unchanged. This is legal even when full, but mem_ready still reads 0 while full: no combinational ready-from-pop path.
- Output selection each cycle, in priority order:
  - If starve_cnt==STARVE_MAX and the FIFO is non-empty, pop the head. alu_ready=0 this cycle.
  - Else if a valid, unfiltered ALU request is present, emit the ALU write.
  - Else if the FIFO is non-empty, pop the head.
  - Else RegW=0 next cycle.
- Starvation counter:
  - Increments when the FIFO is non-empty and the ALU wins.
  - Clears to 0 on any FIFO pop or when the FIFO is empty.
  - Saturates at STARVE_MAX.
- alu_ready = !(starve_cnt==STARVE_MAX && busy). The upstream stage holds its result while alu_ready=0.
- q_pending is combinational:
  - It is 1 if (RegW && Rd==q_reg) or any valid FIFO entry has rd==q_reg.
  - It is 0 when q_reg==0.
- Ordering between ALU and load writes to the same register is not guaranteed. Issue logic must stall on q_pending.

## Timing
- Reset values:
  - RegW=0, Rd=0, wrData=0, err=0.
  - FIFO empty, pointers 0, starve_cnt=0.
  - Hence mem_ready=1, alu_ready=1, busy=0, q_pending=0.
- Reset asserted mid-operation discards all queued entries on that edge. No write is emitted in the following cycle.
- Latency:
  - ALU write: accepted in cycle N, RegW=1 in cycle N+1. The bank commits on edge N+2.
  - Load into an empty FIFO with no ALU request: pushed at edge N, popped in cycle N+1, on the output in cycle N+2.
- Output registers update every cycle. RegW is a single-cycle pulse per write, and Rd/wrData are held while RegW=0.
- err is set on the edge following the offending transfer and cleared only by reset.

## Test plan
- Reset, then alu_valid=1, alu_rd=3, alu_data=0x11 for one cycle -> next cycle RegW=1, Rd=3, wrData=0x11; the cycle after RegW=0.
- Four loads to R1..R4 (data 0xA1..0xA4) with ALU idle -> writes appear in order on consecutive cycles. mem_ready stays 1; busy falls after the last pop.
- Six loads pushed back-to-back while alu_valid is held high to R5 -> mem_ready=0 after 4 pushes. alu_ready drops every 4th cycle (STARVE_MAX=3) and the FIFO head is emitted; all loads drain in order with no loss.
- alu_rd=0 and mem_rd=0 requests -> no RegW pulse; FIFO count unchanged. mem_rd=17 -> dropped, err=1 and stays 1.
- Load to R7 queued behind a full FIFO, q_reg=7 -> q_pending=1 until the cycle after R7's RegW pulse, then 0. q_reg=0 -> always 0.
- FIFO holding 3 entries, reset asserted one cycle -> next cycle RegW=0, busy=0, mem_ready=1; no queued write emerges.
